// File: rtl/cv32e40x_prefetch_controller_if.sv
// Instruction bus between the prefetch controller and instruction memory.
// The controller uses the master modport, the memory side the slave modport.
interface cv32e40x_prefetch_controller_if;
    logic        instr_req_o;
    logic        instr_gnt_i;
    logic [31:0] instr_addr_o;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;

    modport master (
        output instr_req_o,
        output instr_addr_o,
        input  instr_gnt_i,
        input  instr_rvalid_i,
        input  instr_rdata_i,
        input  instr_err_i
    );

    modport slave (
        input  instr_req_o,
        input  instr_addr_o,
        output instr_gnt_i,
        output instr_rvalid_i,
        output instr_rdata_i,
        output instr_err_i
    );
endinterface

// File: rtl/cv32e40x_prefetch_controller.sv
// Instruction prefetch controller: issues bus requests, tracks outstanding
// transfers, flushes stale responses. Define CV32E40X_FETCH_ERR_EN for errors.
module cv32e40x_prefetch_controller #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        trans_req_i,
    output logic        trans_ack_o,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_rdata_o,
    output logic        fetch_err_o,
    output logic        busy_o,
    cv32e40x_prefetch_controller_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        BRANCH_WAIT
    } state_e;

    localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

    state_e      state_q;
    logic [31:0] next_addr_q;
    logic [31:0] pend_addr_q;
    logic [31:0] addr_q;
    logic        pend_q;
    logic        held_q;
    logic [1:0]  outstanding_q;
    logic [1:0]  flush_cnt_q;

    logic [31:0] br_addr;
    logic [31:0] addr;
    logic [31:0] redirect;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic        room;
    logic        stale;
    logic        discard;
    logic [1:0]  out_n;
    logic [1:0]  flush_n;
    logic [1:0]  unused_addr_lsb;

    assign br_addr         = {branch_addr_i[31:2], 2'b00};
    assign unused_addr_lsb = branch_addr_i[1:0];
    assign rvalid          = bus.instr_rvalid_i;
    assign room            = (outstanding_q < MAX_CNT) | rvalid;

    always_comb begin
        req  = 1'b0;
        addr = next_addr_q;
        case (state_q)
            IDLE: begin
                req  = req_i & (branch_i | trans_req_i) & room;
                addr = branch_i ? br_addr : next_addr_q;
            end
            WAIT_GNT, BRANCH_WAIT: begin
                // A request already on the bus must not be withdrawn
                req  = held_q | room;
                addr = addr_q;
            end
            default: ;
        endcase
    end

    assign gnt      = req & bus.instr_gnt_i;
    assign stale    = (state_q != IDLE) & (pend_q | branch_i);
    assign discard  = gnt & stale;
    assign redirect = branch_i ? br_addr : pend_addr_q;

    always_comb begin
        out_n = outstanding_q + {1'b0, gnt} - {1'b0, rvalid};
        if (branch_i) begin
            flush_n = outstanding_q - {1'b0, rvalid} + {1'b0, discard};
        end else begin
            flush_n = flush_cnt_q
                    - {1'b0, rvalid && (flush_cnt_q != 2'd0)}
                    + {1'b0, discard};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            next_addr_q   <= '0;
            pend_addr_q   <= '0;
            addr_q        <= '0;
            pend_q        <= 1'b0;
            held_q        <= 1'b0;
            outstanding_q <= '0;
            flush_cnt_q   <= '0;
        end else begin
            outstanding_q <= out_n;
            flush_cnt_q   <= flush_n;
            case (state_q)
                IDLE: begin
                    if (branch_i) begin
                        if (gnt) begin
                            next_addr_q <= br_addr + 32'd4;
                        end else if (!req_i) begin
                            next_addr_q <= br_addr;
                        end else begin
                            addr_q      <= br_addr;
                            pend_addr_q <= br_addr;
                            pend_q      <= 1'b0;
                            held_q      <= req;
                            state_q     <= BRANCH_WAIT;
                        end
                    end else if (gnt) begin
                        next_addr_q <= next_addr_q + 32'd4;
                    end else if (req) begin
                        addr_q  <= next_addr_q;
                        held_q  <= 1'b1;
                        state_q <= WAIT_GNT;
                    end
                end
                WAIT_GNT, BRANCH_WAIT: begin
                    if (gnt) begin
                        held_q <= 1'b0;
                        pend_q <= 1'b0;
                        if (stale) begin
                            addr_q      <= redirect;
                            pend_addr_q <= redirect;
                            state_q     <= BRANCH_WAIT;
                        end else begin
                            next_addr_q <= addr_q + 32'd4;
                            state_q     <= IDLE;
                        end
                    end else begin
                        held_q <= req;
                        if (branch_i) begin
                            pend_addr_q <= br_addr;
                            // Retarget directly if nothing is on the bus yet
                            if (req) begin
                                pend_q <= 1'b1;
                            end else begin
                                addr_q <= br_addr;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.instr_req_o  = rst_n & req;
    assign bus.instr_addr_o = rst_n ? addr : 32'd0;
    assign trans_ack_o      = rst_n & gnt;
    assign fetch_valid_o    = rst_n & rvalid & (flush_cnt_q == 2'd0);
    assign fetch_rdata_o    = rst_n ? bus.instr_rdata_i : 32'd0;
    assign busy_o           = rst_n & ((outstanding_q != 2'd0) | req
                                       | (state_q != IDLE));

`ifdef CV32E40X_FETCH_ERR_EN
    assign fetch_err_o = bus.instr_err_i & fetch_valid_o;
`else
    logic unused_err;
    assign unused_err  = bus.instr_err_i;
    assign fetch_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40x_prefetch_controller.sv
// Directed vector bench for the prefetch controller: per-cycle stimulus
// records with hand-computed expected outputs.
module tb_cv32e40x_prefetch_controller;

    typedef struct {
        logic        rq;
        logic        br;
        logic [31:0] ba;
        logic        tr;
        logic        gn;
        logic        rv;
        logic [31:0] rd;
        logic        er;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ack;
        logic        e_fv;
        logic        e_fe;
        logic        e_busy;
        logic [31:0] e_rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        trans_req_i;
    logic        trans_ack_o;
    logic        fetch_valid_o;
    logic [31:0] fetch_rdata_o;
    logic        fetch_err_o;
    logic        busy_o;

    int nvec = 0;
    int nerr = 0;

    cv32e40x_prefetch_controller_if bus ();

    cv32e40x_prefetch_controller #(.MAX_OUTSTANDING(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .trans_req_i   (trans_req_i),
        .trans_ack_o   (trans_ack_o),
        .fetch_valid_o (fetch_valid_o),
        .fetch_rdata_o (fetch_rdata_o),
        .fetch_err_o   (fetch_err_o),
        .busy_o        (busy_o),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        logic rq, logic br, logic [31:0] ba, logic tr,
        logic gn, logic rv, logic [31:0] rd, logic er,
        logic q, logic [31:0] a, logic ak, logic fv,
        logic fe, logic bsy);
        vec_t v;
        v.rq = rq; v.br = br; v.ba = ba; v.tr = tr;
        v.gn = gn; v.rv = rv; v.rd = rd; v.er = er;
        v.e_req = q; v.e_addr = a; v.e_ack = ak;
        v.e_fv = fv; v.e_fe = fe; v.e_busy = bsy;
        v.e_rd = rd;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        req_i              = v.rq;
        branch_i           = v.br;
        branch_addr_i      = v.ba;
        trans_req_i        = v.tr;
        bus.instr_gnt_i    = v.gn;
        bus.instr_rvalid_i = v.rv;
        bus.instr_rdata_i  = v.rd;
        bus.instr_err_i    = v.er;
    endtask

    task automatic check(input string nm, input vec_t v);
        logic [69:0] got;
        logic [69:0] exp;
        logic        fe;
`ifdef CV32E40X_FETCH_ERR_EN
        fe = v.e_fe;
`else
        fe = 1'b0;
`endif
        got = {bus.instr_req_o, bus.instr_addr_o, trans_ack_o,
               fetch_valid_o, fetch_err_o, busy_o, fetch_rdata_o};
        exp = {v.e_req, v.e_addr, v.e_ack, v.e_fv, fe, v.e_busy, v.e_rd};
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: req/addr/ack/fv/fe/busy/rdata got=%h exp=%h",
                     nm, got, exp);
        end
    endtask

    vec_t tbl[32];
    vec_t zero;
    vec_t r;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        zero = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0);
        // sequential fetch, response one cycle after grant
        tbl[0]  = mk(1,0,0,1, 1,0,0,0,        1,32'h0,1,0,0,1);
        tbl[1]  = mk(1,0,0,1, 1,1,32'hA1,0,   1,32'h4,1,1,0,1);
        tbl[2]  = mk(1,0,0,1, 1,1,32'hA2,0,   1,32'h8,1,1,0,1);
        tbl[3]  = mk(1,0,0,0, 0,1,32'hA3,0,   0,32'hC,0,1,0,1);
        tbl[4]  = mk(0,0,0,0, 0,0,0,0,        0,32'hC,0,0,0,0);
        // outstanding limit of 2
        tbl[5]  = mk(1,0,0,1, 1,0,0,0,        1,32'hC,1,0,0,1);
        tbl[6]  = mk(1,0,0,1, 1,0,0,0,        1,32'h10,1,0,0,1);
        tbl[7]  = mk(1,0,0,1, 1,0,0,0,        0,32'h14,0,0,0,1);
        tbl[8]  = mk(1,0,0,1, 1,0,0,0,        0,32'h14,0,0,0,1);
        tbl[9]  = mk(1,0,0,1, 1,1,32'hB9,0,   1,32'h14,1,1,0,1);
        // branch with 2 outstanding: two responses flushed
        tbl[10] = mk(1,1,32'h102,0, 1,0,0,0,  0,32'h100,0,0,0,1);
        tbl[11] = mk(1,0,0,0, 0,1,32'hD1,0,   1,32'h100,0,0,0,1);
        tbl[12] = mk(1,0,0,0, 1,1,32'hD2,0,   1,32'h100,1,0,0,1);
        tbl[13] = mk(1,0,0,0, 0,1,32'hD3,0,   0,32'h104,0,1,0,1);
        tbl[14] = mk(0,0,0,0, 0,0,0,0,        0,32'h104,0,0,0,0);
        // branch during WAIT_GNT
        tbl[15] = mk(1,1,32'h1C,0, 1,0,0,0,   1,32'h1C,1,0,0,1);
        tbl[16] = mk(1,0,0,1, 0,1,32'hE6,0,   1,32'h20,0,1,0,1);
        tbl[17] = mk(0,1,32'h80,0, 0,0,0,0,   1,32'h20,0,0,0,1);
        tbl[18] = mk(0,0,0,0, 0,0,0,0,        1,32'h20,0,0,0,1);
        tbl[19] = mk(0,0,0,0, 1,0,0,0,        1,32'h20,1,0,0,1);
        tbl[20] = mk(0,0,0,0, 0,1,32'hE20,0,  1,32'h80,0,0,0,1);
        tbl[21] = mk(0,0,0,0, 1,0,0,0,        1,32'h80,1,0,0,1);
        tbl[22] = mk(0,0,0,0, 0,1,32'hE22,1,  0,32'h84,0,1,1,1);
        tbl[23] = mk(0,0,0,0, 0,0,0,0,        0,32'h84,0,0,0,0);
        // branch during BRANCH_WAIT
        tbl[24] = mk(1,1,32'h200,0, 0,0,0,0,  1,32'h200,0,0,0,1);
        tbl[25] = mk(1,1,32'h300,0, 0,0,0,0,  1,32'h200,0,0,0,1);
        tbl[26] = mk(1,0,0,0, 1,0,0,0,        1,32'h200,1,0,0,1);
        tbl[27] = mk(1,0,0,0, 1,1,32'hF7,0,   1,32'h300,1,0,0,1);
        tbl[28] = mk(0,0,0,0, 0,1,32'hF8,1,   0,32'h304,0,1,1,1);
        // address wrap, then park in WAIT_GNT
        tbl[29] = mk(1,1,32'hFFFFFFFE,0, 1,0,0,0,
                     1,32'hFFFFFFFC,1,0,0,1);
        tbl[30] = mk(1,0,0,1, 0,1,32'h99,0,   1,32'h0,0,1,0,1);
        tbl[31] = mk(0,0,0,0, 0,0,0,0,        1,32'h0,0,0,0,1);

        rst_n = 1'b0;
        drive(zero);
        repeat (2) @(negedge clk);
        r = mk(1,1,32'h40,1, 1,1,32'hCAFE,1, 0,0,0,0,0,0);
        r.e_rd = 32'h0;
        drive(r);
        #1 check("reset_outputs", r);

        @(negedge clk);
        rst_n = 1'b1;
        drive(zero);
        #1 check("post_reset_idle", zero);

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1 check($sformatf("vec%0d", i), tbl[i]);
        end

        // reset pulsed while in WAIT_GNT
        @(negedge clk);
        rst_n = 1'b0;
        r = mk(1,0,0,1, 1,1,32'hBEEF,1, 0,0,0,0,0,0);
        r.e_rd = 32'h0;
        drive(r);
        #1 check("reset_in_wait_gnt", r);
        @(negedge clk);
        rst_n = 1'b1;
        drive(zero);
        #1 check("after_reset_idle", zero);
        @(negedge clk);
        r = mk(1,0,0,1, 1,0,0,0, 1,32'h0,1,0,0,1);
        drive(r);
        #1 check("after_reset_fetch", r);
        @(negedge clk);
        r = mk(0,0,0,0, 0,1,32'h5,0, 0,32'h4,0,1,0,1);
        drive(r);
        #1 check("after_reset_resp", r);
        @(negedge clk);
        drive(zero);
        r = mk(0,0,0,0, 0,0,0,0, 0,32'h4,0,0,0,0);
        #1 check("after_reset_drained", r);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
